// File: rtl/systolic_quant_pack_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_quant_pack_if : 64-bit beat stream toward the write-back buffer
// Rev 1.0
// ---------------------------------------------------------------------------
interface systolic_quant_pack_if;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;

   modport master (output out_valid, output out_data, output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface
`default_nettype wire

// File: rtl/systolic_quant_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// systolic_quant_pack : bias + ReLU + shift + saturate, 2-deep frame FIFO,
// 4x64-bit beat output. Optional rounding: QUANT_ROUND_EN. Rev 1.0
// ---------------------------------------------------------------------------
module systolic_quant_pack #(
   parameter int DATA_WIDTH_I = 22,
   parameter int BIAS_WIDTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [3:0]                shift,
   input  logic [BIAS_WIDTH-1:0]     bias0,
   input  logic [BIAS_WIDTH-1:0]     bias1,
   input  logic [15:0]               en_in,
   input  logic [DATA_WIDTH_I*16-1:0] din0,
   input  logic [DATA_WIDTH_I*16-1:0] din1,
   systolic_quant_pack_if.master     out_if,
   output logic                      overflow,
   output logic                      busy
);
   localparam int DW = DATA_WIDTH_I;
   localparam logic [DW:0] c_one = (DW+1)'(1);
   localparam logic [DW:0] c_sat = (DW+1)'(127);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

   logic [15:0][DW:0] w_sum0, w_sum1;
   logic [255:0]      w_frame;
   logic              r_s1_valid, r_s2_valid;
   logic [15:0]       r_s1_en;
   logic [15:0][DW:0] r_s1_sum0, r_s1_sum1;
   logic [255:0]      r_s2_frame;
   logic [3:0]        r_shift;
   logic [255:0]      r_mem [2];
   logic              r_wptr, r_rptr;
   logic [1:0]        r_count;
   state_t            r_state;
   logic [1:0]        r_beat;
   logic              r_out_valid, r_out_last, r_overflow;
   logic [63:0]       r_out_data;
   logic              w_pop, w_push, w_drop;
   logic [1:0]        w_count_nxt;
   logic [255:0]      w_next_frame;

   // Sum is signed DW+1 bits; negative clamps to zero before any rounding.
   function automatic logic [7:0] f_quant(input logic [DW:0] sum, input logic [3:0] sh);
      logic [DW:0] v;
      logic [DW:0] s;
      v = sum[DW] ? '0 : sum;
`ifdef QUANT_ROUND_EN
      if (sh != 4'd0) v = v + (c_one << (sh - 4'd1));
`endif
      s = v >> sh;
      return (s > c_sat) ? 8'd127 : s[7:0];
   endfunction

   function automatic logic [63:0] f_beat(input logic [255:0] f, input logic [1:0] b);
      return f[{b, 6'b0} +: 64];
   endfunction

   generate
      for (genvar i = 0; i < 16; i++) begin : g_lane
         assign w_sum0[i] = {din0[DW*i+DW-1], din0[DW*i +: DW]}
                          + {{(DW+1-BIAS_WIDTH){bias0[BIAS_WIDTH-1]}}, bias0};
         assign w_sum1[i] = {din1[DW*i+DW-1], din1[DW*i +: DW]}
                          + {{(DW+1-BIAS_WIDTH){bias1[BIAS_WIDTH-1]}}, bias1};
         assign w_frame[8*i +: 8]      = r_s1_en[i] ? f_quant(r_s1_sum0[i], r_shift) : 8'd0;
         assign w_frame[8*(16+i) +: 8] = r_s1_en[i] ? f_quant(r_s1_sum1[i], r_shift) : 8'd0;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1_valid <= 1'b0;
         r_s1_en    <= '0;
         r_s1_sum0  <= '0;
         r_s1_sum1  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_frame <= '0;
         r_shift    <= '0;
      end else begin
         r_s1_valid <= |en_in;
         r_s1_en    <= en_in;
         r_s1_sum0  <= w_sum0;
         r_s1_sum1  <= w_sum1;
         r_s2_valid <= r_s1_valid;
         r_s2_frame <= w_frame;
         if (start) r_shift <= shift;
      end
   end

   // When one frame is resident and a new one lands on the final-beat pop,
   // the next frame is taken straight from stage 2 since the FIFO write is not yet visible.
   always_comb begin
      w_pop        = (r_state == S_SEND) && out_if.out_ready && (r_beat == 2'd3);
      w_push       = r_s2_valid && ((r_count != 2'd2) || w_pop);
      w_drop       = r_s2_valid && !w_push;
      w_count_nxt  = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
      else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
      w_next_frame = (r_count == 2'd1) ? r_s2_frame : r_mem[~r_rptr];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2; k++) r_mem[k] <= '0;
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= r_s2_frame;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         r_count <= w_count_nxt;
         if (start)  r_overflow <= 1'b0;
         if (w_drop) r_overflow <= 1'b1;

         case (r_state)
            S_IDLE: begin
               if (r_count != 2'd0) begin
                  r_state     <= S_SEND;
                  r_out_valid <= 1'b1;
                  r_beat      <= 2'd0;
                  r_out_data  <= f_beat(r_mem[r_rptr], 2'd0);
                  r_out_last  <= 1'b0;
               end
            end
            S_SEND: begin
               if (out_if.out_ready) begin
                  if (r_beat == 2'd3) begin
                     r_beat     <= 2'd0;
                     r_out_last <= 1'b0;
                     if (w_count_nxt != 2'd0) begin
                        r_out_data <= f_beat(w_next_frame, 2'd0);
                     end else begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                     end
                  end else begin
                     r_beat     <= r_beat + 2'd1;
                     r_out_data <= f_beat(r_mem[r_rptr], r_beat + 2'd1);
                     r_out_last <= (r_beat == 2'd2);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_if.out_valid = r_out_valid;
   assign out_if.out_data  = r_out_data;
   assign out_if.out_last  = r_out_last;
   assign overflow         = r_overflow;
   assign busy             = r_s1_valid | r_s2_valid | (r_count != 2'd0);
endmodule
`default_nettype wire

// File: tb/tb_systolic_quant_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_systolic_quant_pack : randomized scoreboard bench for systolic_quant_pack
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_systolic_quant_pack;
   localparam int DW = 22;
   localparam int BW = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [3:0]        shift = '0;
   logic [BW-1:0]     bias0 = '0, bias1 = '0;
   logic [15:0]       en_in = '0;
   logic [DW*16-1:0]  din0 = '0, din1 = '0;
   logic              overflow, busy;

   systolic_quant_pack_if u_if();

   systolic_quant_pack #(.DATA_WIDTH_I(DW), .BIAS_WIDTH(BW)) u_dut (
      .clk(clk), .rst(rst), .start(start), .shift(shift),
      .bias0(bias0), .bias1(bias1), .en_in(en_in),
      .din0(din0), .din1(din1), .out_if(u_if),
      .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [64:0]  exp_q [$];
   int           d0 [16];
   int           d1 [16];
   int           b0 = 0, b1 = 0, shm = 0;
   int           ready_mode = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the lane value.
   function automatic logic [7:0] m_q(input int d, input int b, input int sh);
      longint s;
      s = longint'(d) + longint'(b);
      if (s < 0) return 8'd0;
`ifdef QUANT_ROUND_EN
      if (sh > 0) s = s + (longint'(1) << (sh - 1));
`endif
      s = s >>> sh;
      if (s > 127) s = 127;
      return 8'(s);
   endfunction

   function automatic int rnd_lane();
      logic signed [DW-1:0] t;
      if ($urandom_range(0, 7) == 0) begin
         t = DW'($urandom);
         return int'(t);
      end
      return int'($urandom_range(0, 6000)) - 1500;
   endfunction

   task automatic nc();
      @(negedge clk);
      #2;
   endtask

   task automatic rand_lanes();
      for (int i = 0; i < 16; i++) begin
         d0[i] = rnd_lane();
         d1[i] = rnd_lane();
      end
   endtask

   task automatic do_start(input int sh);
      start = 1'b1;
      shift = 4'(sh);
      shm   = sh;
      nc();
      start = 1'b0;
   endtask

   task automatic drive_frame(input logic [15:0] en, input bit keep);
      logic [255:0] fr;
      int           tmp;
      for (int i = 0; i < 16; i++) begin
         tmp = d0[i]; din0[DW*i +: DW] = tmp[DW-1:0];
         tmp = d1[i]; din1[DW*i +: DW] = tmp[DW-1:0];
         fr[8*i +: 8]      = en[i] ? m_q(d0[i], b0, shm) : 8'd0;
         fr[8*(16+i) +: 8] = en[i] ? m_q(d1[i], b1, shm) : 8'd0;
      end
      tmp = b0; bias0 = tmp[BW-1:0];
      tmp = b1; bias1 = tmp[BW-1:0];
      en_in = en;
      if (keep)
         for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), fr[64*k +: 64]});
      nc();
      en_in = '0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || busy) && c < budget) begin
         nc();
         c++;
      end
      chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_busy"}, {63'b0, busy}, 64'd0);
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      case (ready_mode)
         0:       u_if.out_ready = 1'b1;
         1:       u_if.out_ready = 1'b0;
         2:       u_if.out_ready = (u_if.out_ready === 1'b1) ? 1'b0 : 1'b1;
         default: u_if.out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   logic        held = 1'b0;
   logic [63:0] held_d;
   logic        held_l;
   logic [64:0] e;

   always @(negedge clk) begin
      #1;
      if (!rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("stall_valid", {63'b0, u_if.out_valid}, 64'd1);
            chk("stall_data", u_if.out_data, held_d);
            chk("stall_last", {63'b0, u_if.out_last}, {63'b0, held_l});
         end
         if (u_if.out_valid && u_if.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_beat: got %h expected no beat at %0t", u_if.out_data, $time);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", u_if.out_data, e[63:0]);
               chk("beat_last", {63'b0, u_if.out_last}, {63'b0, e[64]});
            end
         end
         held   = u_if.out_valid && !u_if.out_ready;
         held_d = u_if.out_data;
         held_l = u_if.out_last;
      end
   end

   initial begin
      int c;
      repeat (3) nc();
      chk("rst_valid", {63'b0, u_if.out_valid}, 64'd0);
      chk("rst_data", u_if.out_data, 64'd0);
      chk("rst_last", {63'b0, u_if.out_last}, 64'd0);
      chk("rst_overflow", {63'b0, overflow}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      rst = 1'b1;
      nc();

      // Basic frame and latency
      b0 = 0; b1 = 0;
      do_start(4);
      for (int i = 0; i < 16; i++) begin d0[i] = 256; d1[i] = -5; end
      drive_frame(16'hFFFF, 1'b1);
      nc(); nc();
      chk("latency_e2", {63'b0, u_if.out_valid}, 64'd0);
      nc();
      chk("latency_e3", {63'b0, u_if.out_valid}, 64'd1);
      wait_drain("basic", 40);

      // Bias and saturation
      do_start(0);
      rand_lanes(); d0[0] = 1000; b0 = -900; b1 = int'($urandom_range(0, 400)) - 200;
      drive_frame(16'hFFFF, 1'b1);
      rand_lanes(); d0[0] = 200; b0 = 0;
      drive_frame(16'hFFFF, 1'b1);
      wait_drain("bias_sat", 60);

      // Rounding boundary
      do_start(1);
      rand_lanes(); d0[0] = 3; b0 = 0;
      drive_frame(16'hFFFF, 1'b1);
      wait_drain("round", 40);

      // Lane enable masking
      do_start(0); b0 = 0; b1 = 0;
      for (int i = 0; i < 16; i++) begin d0[i] = 10 + i; d1[i] = 40 + i; end
      drive_frame(16'h0001, 1'b1);
      wait_drain("mask", 40);

      // Overflow: two retained, third dropped
      ready_mode = 1;
      do_start(2);
      rand_lanes(); drive_frame(16'hFFFF, 1'b1);
      rand_lanes(); drive_frame(16'hFFFF, 1'b1);
      rand_lanes(); drive_frame(16'hFFFF, 1'b0);
      repeat (4) nc();
      chk("ovf_set", {63'b0, overflow}, 64'd1);
      chk("ovf_valid", {63'b0, u_if.out_valid}, 64'd1);
      ready_mode = 0;
      wait_drain("ovf_drain", 60);
      chk("ovf_sticky", {63'b0, overflow}, 64'd1);
      do_start(2);
      chk("ovf_clear", {63'b0, overflow}, 64'd0);

      // Full throughput, random data
      do_start(int'($urandom_range(0, 6)));
      for (int f = 0; f < 12; f++) begin
         rand_lanes();
         b0 = int'($urandom_range(0, 2000)) - 1000;
         b1 = int'($urandom_range(0, 2000)) - 1000;
         drive_frame(16'($urandom_range(1, 16'hFFFF)), 1'b1);
         repeat (3) nc();
      end
      wait_drain("throughput", 80);
      chk("throughput_no_ovf", {63'b0, overflow}, 64'd0);

      // Toggling and random ready
      for (int m = 2; m < 4; m++) begin
         ready_mode = m;
         do_start(int'($urandom_range(0, 8)));
         for (int f = 0; f < 8; f++) begin
            rand_lanes();
            b0 = int'($urandom_range(0, 2000)) - 1000;
            b1 = int'($urandom_range(0, 2000)) - 1000;
            drive_frame(16'($urandom_range(1, 16'hFFFF)), 1'b1);
            wait_drain("stall", 80);
         end
      end

      // Reset in the middle of a frame
      ready_mode = 2;
      rand_lanes();
      drive_frame(16'hFFFF, 1'b1);
      c = 0;
      while (exp_q.size() > 3 && c < 50) begin nc(); c++; end
      chk("midrst_reached", 64'(exp_q.size()), 64'd3);
      rst = 1'b0;
      #1;
      chk("midrst_valid", {63'b0, u_if.out_valid}, 64'd0);
      chk("midrst_busy", {63'b0, busy}, 64'd0);
      chk("midrst_data", u_if.out_data, 64'd0);
      exp_q.delete();
      nc();
      rst = 1'b1;
      nc();
      ready_mode = 0;
      do_start(3);
      rand_lanes();
      drive_frame(16'hFFFF, 1'b1);
      wait_drain("post_rst", 40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
`default_nettype wire
